algorithm_sum: RTL and testbench

Streaming accumulator: adds one two's-complement integer sample into a running total on every clock edge and presents the total as a registered output. It is the hardware form of the `sum` fold over an input stream. It sits downstream of any per-cycle integer source and feeds consumers that want the running total. The block is purely combinational-adder plus register; there is no handshake.

---
 rtl/algorithm_sum_if.sv | 20 ++
 rtl/algorithm_sum.sv | 51 +++++
 tb/tb_algorithm_sum.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/algorithm_sum_if.sv
// algorithm_sum_if
//   Bundles the sample stream and the running-total return path of the
//   streaming accumulator so a source and its consumer share one port.
//
//   Signals:
//     sIn  signed WIDTH  sample presented to the accumulator every cycle
//     sum  signed WIDTH  registered running total returned by the accumulator
//
//   Modports:
//     master  drives sIn, observes sum (sample source / consumer side)
//     slave   observes sIn, drives sum (accumulator side)
interface algorithm_sum_if #(
  parameter int WIDTH = 8
);
  logic signed [WIDTH-1:0] sIn;
  logic signed [WIDTH-1:0] sum;

  modport master (output sIn, input  sum);
  modport slave  (input  sIn, output sum);
endinterface

// File: rtl/algorithm_sum.sv
// algorithm_sum
//   Streaming accumulator: every rising clock edge the incoming signed sample
//   is added into a running total, which is presented as a registered output.
//   Arithmetic wraps modulo 2^WIDTH (two's complement); there is no
//   saturation and no overflow indication.
//
//   Ports:
//     clk   input   rising-edge clock
//     nrst  input   asynchronous, active-low reset; clears the total to 0
//     bus   slave   algorithm_sum_if: bus.sIn sample in, bus.sum total out
//
//   Latency is one cycle; one sample is consumed every cycle. There is no
//   combinational path from bus.sIn to bus.sum.
module algorithm_sum #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            nrst,
  algorithm_sum_if.slave  bus
);

  // Wrapping add: the carry out of the top bit is intentionally dropped, so
  // 0x7F + 0x01 lands on 0x80 rather than clamping.
  function automatic logic signed [WIDTH-1:0] add_wrap(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] res;
    res = a + b;
    return res;
  endfunction

  logic signed [WIDTH-1:0] w_sin_p0;
  logic signed [WIDTH-1:0] r_acc_p1;

  assign w_sin_p0 = bus.sIn;

  // ---- stage p0 -> p1: accumulate sample into the running total ----
  // The total is architectural state visible on the output, so it is cleared
  // by reset; reset wins over a coincident clock edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_acc_p1 <= '0;
    end else begin
      r_acc_p1 <= add_wrap(r_acc_p1, w_sin_p0);
    end
  end

  assign bus.sum = r_acc_p1;

endmodule

// File: tb/tb_algorithm_sum.sv
module tb_algorithm_sum;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] exp_sum;
  } vec_t;

  logic clk;
  logic nrst;

  algorithm_sum_if #(.WIDTH(WIDTH)) u_if ();

  algorithm_sum #(.WIDTH(WIDTH)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Drive one sample at the falling edge, queue its expected total, then
  // compare just after the next rising edge.
  task automatic step(input string name, input logic [WIDTH-1:0] s,
                      input logic [WIDTH-1:0] exp);
    logic [WIDTH-1:0] e;
    @(negedge clk);
    u_if.sIn = s;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: scoreboard empty, got 0x%02h", name, u_if.sum);
    end else begin
      e = exp_q.pop_front();
      chk(name, u_if.sum, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[$];

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs.push_back('{8'h00, 8'h00});
    vecs.push_back('{8'h01, 8'h01});
    vecs.push_back('{8'h02, 8'h03});
    vecs.push_back('{8'h03, 8'h06});
    vecs.push_back('{8'hFF, 8'h05});
    vecs.push_back('{8'hFF, 8'h04});
    vecs.push_back('{8'hFF, 8'h03});
    vecs.push_back('{8'hFF, 8'h02});
    vecs.push_back('{8'hFF, 8'h01});
    vecs.push_back('{8'h7E, 8'h7F});
    vecs.push_back('{8'h01, 8'h80});
    vecs.push_back('{8'h80, 8'h00});
    vecs.push_back('{8'h2A, 8'h2A});

    // Reset held low across clock edges with a nonzero sample.
    nrst     = 1'b0;
    u_if.sIn = 8'h05;
    #1;
    chk("reset_initial", u_if.sum, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("reset_hold_%0d", i), u_if.sum, 8'h00);
    end

    @(negedge clk);
    u_if.sIn = 8'h00;
    nrst     = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec_%0d", i), vecs[i].s_in, vecs[i].exp_sum);
    end

    // Asynchronous reset pulse between edges with sum at 0x2A.
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    chk("async_reset_mid", u_if.sum, 8'h00);
    u_if.sIn = 8'h10;
    #1;
    nrst = 1'b1;
    #1;
    chk("async_reset_before_edge", u_if.sum, 8'h00);
    @(posedge clk);
    #1;
    chk("restart_after_reset", u_if.sum, 8'h10);

    // Idle hold: zero samples leave the total unchanged.
    for (int i = 0; i < 4; i++) begin
      step($sformatf("idle_%0d", i), 8'h00, 8'h10);
    end

    // Only the value present at the edge counts.
    @(negedge clk);
    u_if.sIn = 8'h05;
    #2;
    u_if.sIn = 8'h03;
    #1;
    chk("between_edges_no_effect", u_if.sum, 8'h10);
    @(posedge clk);
    #1;
    chk("sample_at_edge", u_if.sum, 8'h13);

    // Negative wrap: 0x13 + 0xE0 = 0xF3.
    step("neg_wrap", 8'hE0, 8'hF3);

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
